// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the pipeline MEM stage and the loader/debug port.
// Latency: grant and memory drive are same-cycle combinational; loader read data returns 1 cycle after its grant edge.
// Backpressure: the pipeline gets p_stall when it loses; the loader simply waits for l_gnt, with a starvation bound and a lock mode.
module dmem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_en,
    input  logic              p_rw,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_stall,
    input  logic              l_req,
    input  logic              l_lock,
    input  logic              l_rw,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    logic             pipe_gnt;
    logic             ldr_gnt;
    logic             starved;

    assign starved = (starve_cnt >= CNT_W'(STARVE_MAX));

    // Grant decision; everything is held quiet while reset is asserted.
    always_comb begin
        pipe_gnt = 1'b0;
        ldr_gnt  = 1'b0;
        if (reset) begin
            case (state)
                ARB: begin
                    if (!l_req)
                        pipe_gnt = p_en;
                    else if (!p_en)
                        ldr_gnt = 1'b1;
                    else if (!starved)
                        pipe_gnt = 1'b1;
                    else
                        ldr_gnt = 1'b1;
                end
                LOCK: begin
                    ldr_gnt = l_req;
                end
                default: begin
                    pipe_gnt = 1'b0;
                    ldr_gnt  = 1'b0;
                end
            endcase
        end
    end

    assign l_gnt   = ldr_gnt;
    assign p_stall = reset & p_en & ~pipe_gnt;

    always_comb begin
        mem_en   = 1'b0;
        mem_rw   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (ldr_gnt) begin
            mem_en   = 1'b1;
            mem_rw   = l_rw;
            mem_addr = l_addr;
            mem_din  = l_wdata;
        end else if (pipe_gnt) begin
            mem_en   = 1'b1;
            mem_rw   = p_rw;
            mem_addr = p_addr;
            mem_din  = p_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ARB;
            starve_cnt <= '0;
            l_rvalid   <= 1'b0;
        end else begin
            l_rvalid <= ldr_gnt & ~l_rw;
            case (state)
                ARB: begin
                    // Only a pipeline win over a waiting loader counts toward starvation.
                    if (l_req && p_en && pipe_gnt)
                        starve_cnt <= starve_cnt + CNT_W'(1);
                    else
                        starve_cnt <= '0;
                    if (ldr_gnt && l_lock)
                        state <= LOCK;
                end
                LOCK: begin
                    starve_cnt <= '0;
                    if (!(l_req && l_lock))
                        state <= ARB;
                end
                default: begin
                    state      <= ARB;
                    starve_cnt <= '0;
                end
            endcase
        end
    end

    assign l_rdata = l_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256x8 synchronous memory.
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       p_en = 1'b0, p_rw = 1'b0;
    logic [7:0] p_addr = 8'h00, p_wdata = 8'h00;
    logic       l_req = 1'b0, l_lock = 1'b0, l_rw = 1'b0;
    logic [7:0] l_addr = 8'h00, l_wdata = 8'h00;
    logic       p_stall, l_gnt, l_rvalid, mem_en, mem_rw;
    logic [7:0] l_rdata, mem_addr, mem_din;
    logic [7:0] mem_rdata;
    logic       p_stall1, l_gnt1, l_rvalid1, mem_en1, mem_rw1;
    logic [7:0] l_rdata1, mem_addr1, mem_din1;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_rw) mem[mem_addr] <= mem_din;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_MAX(4)) u_dut (
        .clk(clk), .reset(reset),
        .p_en(p_en), .p_rw(p_rw), .p_addr(p_addr), .p_wdata(p_wdata), .p_stall(p_stall),
        .l_req(l_req), .l_lock(l_lock), .l_rw(l_rw), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .mem_rdata(mem_rdata), .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_din(mem_din)
    );

    // Second instance only watched for the STARVE_MAX=1 alternation.
    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_MAX(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .p_en(p_en), .p_rw(p_rw), .p_addr(p_addr), .p_wdata(p_wdata), .p_stall(p_stall1),
        .l_req(l_req), .l_lock(l_lock), .l_rw(l_rw), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt1), .l_rvalid(l_rvalid1), .l_rdata(l_rdata1),
        .mem_rdata(mem_rdata), .mem_en(mem_en1), .mem_rw(mem_rw1), .mem_addr(mem_addr1), .mem_din(mem_din1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        p_en = 1'b0; p_rw = 1'b0; p_addr = 8'h00; p_wdata = 8'h00;
        l_req = 1'b0; l_lock = 1'b0; l_rw = 1'b0; l_addr = 8'h00; l_wdata = 8'h00;
    endtask

    task automatic ldr_write(input logic [7:0] a, input logic [7:0] d);
        p_en = 1'b0; l_req = 1'b1; l_lock = 1'b0; l_rw = 1'b1; l_addr = a; l_wdata = d;
        tick();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            p_en = 1'($urandom); p_rw = 1'($urandom); p_addr = 8'($urandom); p_wdata = 8'($urandom);
            l_req = 1'($urandom); l_lock = 1'($urandom); l_rw = 1'($urandom); l_addr = 8'($urandom);
            settle();
            checks++; if (mem_en !== 1'b0)   begin errors++; $display("FAIL rst_mem_en got %0b exp 0", mem_en); end
            checks++; if (p_stall !== 1'b0)  begin errors++; $display("FAIL rst_p_stall got %0b exp 0", p_stall); end
            checks++; if (l_gnt !== 1'b0)    begin errors++; $display("FAIL rst_l_gnt got %0b exp 0", l_gnt); end
            checks++; if (l_rvalid !== 1'b0) begin errors++; $display("FAIL rst_l_rvalid got %0b exp 0", l_rvalid); end
            tick();
        end
        reset = 1'b1;
        idle_inputs();
        p_en = 1'b1; p_rw = 1'b1; p_addr = 8'h10; p_wdata = 8'hA5;
        settle();
        checks++; if (mem_en !== 1'b1)    begin errors++; $display("FAIL pipe_mem_en got %0b exp 1", mem_en); end
        checks++; if (mem_rw !== 1'b1)    begin errors++; $display("FAIL pipe_mem_rw got %0b exp 1", mem_rw); end
        checks++; if (mem_addr !== 8'h10) begin errors++; $display("FAIL pipe_mem_addr got %h exp 10", mem_addr); end
        checks++; if (mem_din !== 8'hA5)  begin errors++; $display("FAIL pipe_mem_din got %h exp a5", mem_din); end
        checks++; if (p_stall !== 1'b0)   begin errors++; $display("FAIL pipe_p_stall got %0b exp 0", p_stall); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_loader();
        l_req = 1'b1; l_rw = 1'b1; l_addr = 8'h20; l_wdata = 8'h3C;
        settle();
        checks++; if (l_gnt !== 1'b1)  begin errors++; $display("FAIL ld_wr_gnt got %0b exp 1", l_gnt); end
        checks++; if (mem_rw !== 1'b1) begin errors++; $display("FAIL ld_wr_rw got %0b exp 1", mem_rw); end
        tick();
        l_rw = 1'b0;
        settle();
        checks++; if (l_gnt !== 1'b1)    begin errors++; $display("FAIL ld_rd_gnt got %0b exp 1", l_gnt); end
        checks++; if (l_rvalid !== 1'b0) begin errors++; $display("FAIL ld_wr_no_rvalid got %0b exp 0", l_rvalid); end
        tick();
        l_addr = 8'h10;
        settle();
        checks++; if (l_rvalid !== 1'b1) begin errors++; $display("FAIL ld_rvalid got %0b exp 1", l_rvalid); end
        checks++; if (l_rdata !== 8'h3C) begin errors++; $display("FAIL ld_rdata got %h exp 3c", l_rdata); end
        tick();
        l_req = 1'b0;
        settle();
        checks++; if (l_rdata !== 8'hA5) begin errors++; $display("FAIL ld_pipe_wr_seen got %h exp a5", l_rdata); end
        tick();
        settle();
        checks++; if (l_rvalid !== 1'b0) begin errors++; $display("FAIL ld_rvalid_drop got %0b exp 0", l_rvalid); end
        checks++; if (l_rdata !== 8'h00) begin errors++; $display("FAIL ld_rdata_zero got %h exp 00", l_rdata); end
        tick();
    endtask

    task automatic test_starvation();
        logic [7:0] ra [4] = '{8'h44, 8'h43, 8'h49, 8'h50};
        logic [7:0] rd [4] = '{8'hEE, 8'h83, 8'hEE, 8'h77};
        logic       exp_l;
        ldr_write(8'h44, 8'hEE);
        ldr_write(8'h49, 8'hEE);
        idle_inputs();
        tick();
        for (int i = 0; i < 10; i++) begin
            p_en = 1'b1; p_rw = 1'b1; p_addr = 8'h40 + 8'(i); p_wdata = 8'h80 + 8'(i);
            l_req = 1'b1; l_rw = 1'b1; l_lock = 1'b0; l_addr = 8'h50; l_wdata = 8'h77;
            settle();
            exp_l = (i % 5 == 4);
            checks++; if (l_gnt !== exp_l)   begin errors++; $display("FAIL st_l_gnt[%0d] got %0b exp %0b", i, l_gnt, exp_l); end
            checks++; if (p_stall !== exp_l) begin errors++; $display("FAIL st_p_stall[%0d] got %0b exp %0b", i, p_stall, exp_l); end
            checks++; if (mem_addr !== (exp_l ? 8'h50 : 8'h40 + 8'(i)))
                begin errors++; $display("FAIL st_addr[%0d] got %h", i, mem_addr); end
            checks++; if (mem_din !== (exp_l ? 8'h77 : 8'h80 + 8'(i)))
                begin errors++; $display("FAIL st_din[%0d] got %h", i, mem_din); end
            checks++; if (l_gnt1 !== 1'(i % 2)) begin errors++; $display("FAIL st1_l_gnt[%0d] got %0b exp %0b", i, l_gnt1, 1'(i % 2)); end
            checks++; if (p_stall1 !== 1'(i % 2)) begin errors++; $display("FAIL st1_p_stall[%0d] got %0b exp %0b", i, p_stall1, 1'(i % 2)); end
            tick();
        end
        idle_inputs();
        for (int j = 0; j < 5; j++) begin
            if (j < 4) begin l_req = 1'b1; l_rw = 1'b0; l_addr = ra[j]; end
            else l_req = 1'b0;
            settle();
            if (j > 0) begin
                checks++; if (l_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_rvalid[%0d] got %0b exp 1", j, l_rvalid); end
                checks++; if (l_rdata !== rd[j-1]) begin errors++; $display("FAIL b2b_rdata[%0d] got %h exp %h", j, l_rdata, rd[j-1]); end
            end
            tick();
        end
    endtask

    task automatic test_lock();
        for (int i = 0; i < 6; i++) ldr_write(8'(i), 8'hD0 + 8'(i));
        idle_inputs();
        tick();
        for (int i = 0; i < 4; i++) begin
            p_en = 1'b1; p_rw = 1'b0; p_addr = 8'h60;
            l_req = 1'b1; l_lock = 1'b1; l_rw = 1'b0; l_addr = 8'h00;
            settle();
            checks++; if (l_gnt !== 1'b0) begin errors++; $display("FAIL lk_pre_gnt[%0d] got %0b exp 0", i, l_gnt); end
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            l_addr = 8'(i); l_lock = (i < 5);
            settle();
            checks++; if (l_gnt !== 1'b1)    begin errors++; $display("FAIL lk_gnt[%0d] got %0b exp 1", i, l_gnt); end
            checks++; if (p_stall !== 1'b1)  begin errors++; $display("FAIL lk_stall[%0d] got %0b exp 1", i, p_stall); end
            checks++; if (mem_addr !== 8'(i)) begin errors++; $display("FAIL lk_addr[%0d] got %h exp %h", i, mem_addr, 8'(i)); end
            if (i > 0) begin
                checks++; if (l_rdata !== 8'hD0 + 8'(i - 1)) begin errors++; $display("FAIL lk_rdata[%0d] got %h exp %h", i, l_rdata, 8'hD0 + 8'(i - 1)); end
            end
            tick();
        end
        l_req = 1'b0; l_lock = 1'b0;
        settle();
        checks++; if (p_stall !== 1'b0)   begin errors++; $display("FAIL lk_exit_stall got %0b exp 0", p_stall); end
        checks++; if (mem_addr !== 8'h60) begin errors++; $display("FAIL lk_exit_addr got %h exp 60", mem_addr); end
        checks++; if (l_rvalid !== 1'b1)  begin errors++; $display("FAIL lk_last_rvalid got %0b exp 1", l_rvalid); end
        checks++; if (l_rdata !== 8'hD5)  begin errors++; $display("FAIL lk_last_rdata got %h exp d5", l_rdata); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        ldr_write(8'h30, 8'h5A);
        l_rw = 1'b0;
        tick();
        l_req = 1'b0;
        p_en = 1'b1; p_rw = 1'b1; p_addr = 8'h31; p_wdata = 8'h6B;
        settle();
        checks++; if (l_rdata !== 8'h5A) begin errors++; $display("FAIL wr_rd_ldr got %h exp 5a", l_rdata); end
        tick();
        p_en = 1'b0; l_req = 1'b1; l_rw = 1'b0; l_addr = 8'h31;
        tick();
        idle_inputs();
        settle();
        checks++; if (l_rdata !== 8'h6B) begin errors++; $display("FAIL wr_rd_pipe got %h exp 6b", l_rdata); end
        tick();
    endtask

    task automatic test_reset_lock();
        l_req = 1'b1; l_lock = 1'b1; l_rw = 1'b0; l_addr = 8'h00;
        tick();
        p_en = 1'b1; p_rw = 1'b1; p_addr = 8'h62; p_wdata = 8'h11; l_addr = 8'h01;
        settle();
        checks++; if (p_stall !== 1'b1) begin errors++; $display("FAIL rl_stall got %0b exp 1", p_stall); end
        tick();
        l_addr = 8'h02;
        settle();
        checks++; if (l_rvalid !== 1'b1) begin errors++; $display("FAIL rl_pre_rvalid got %0b exp 1", l_rvalid); end
        reset = 1'b0;
        #1;
        checks++; if (l_rvalid !== 1'b0) begin errors++; $display("FAIL rl_rvalid_clr got %0b exp 0", l_rvalid); end
        checks++; if (l_gnt !== 1'b0)    begin errors++; $display("FAIL rl_gnt got %0b exp 0", l_gnt); end
        checks++; if (mem_en !== 1'b0)   begin errors++; $display("FAIL rl_mem_en got %0b exp 0", mem_en); end
        tick();
        reset = 1'b1;
        p_en = 1'b1; p_rw = 1'b0; p_addr = 8'h61; l_req = 1'b1; l_lock = 1'b0; l_addr = 8'h02;
        settle();
        checks++; if (p_stall !== 1'b0)   begin errors++; $display("FAIL rl_after_stall got %0b exp 0", p_stall); end
        checks++; if (l_gnt !== 1'b0)     begin errors++; $display("FAIL rl_after_gnt got %0b exp 0", l_gnt); end
        checks++; if (mem_addr !== 8'h61) begin errors++; $display("FAIL rl_after_addr got %h exp 61", mem_addr); end
        tick();
        settle();
        checks++; if (l_rvalid !== 1'b0) begin errors++; $display("FAIL rl_no_rvalid got %0b exp 0", l_rvalid); end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_loader();
        test_starvation();
        test_lock();
        test_back_to_back();
        test_reset_lock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 256x8 synchronous data memory between two requesters: the pipeline MEM-stage access and a loader/debug port.
- The loader port is used for program/data preload and for run-time inspection.
- The pipeline normally has priority. A starvation counter and a lock (burst) mode guarantee loader progress by stalling the pipeline.
- Sits between the EX/MEM boundary and the data memory core; drives the memory's en/we/addr/din.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 8, memory data width
STARVE_MAX, 4, consecutive pipeline grants allowed while the loader waits (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
p_en  in  1  pipeline requests a memory access this cycle
p_rw  in  1  pipeline direction, 1=write 0=read
p_addr  in  ADDR_W  pipeline address (ALU result)
p_wdata  in  DATA_W  pipeline store data (bypassed B operand)
p_stall  out  1  pipeline must hold its EX/MEM inputs; its access was not performed
l_req  in  1  loader requests an access
l_lock  in  1  loader requests to keep ownership after this grant (burst)
l_rw  in  1  loader direction, 1=write
l_addr  in  ADDR_W  loader address
l_wdata  in  DATA_W  loader write data
l_gnt  out  1  loader access performed at this clock edge
l_rvalid  out  1  loader read data valid (registered)
l_rdata  out  DATA_W  loader read data
mem_rdata  in  DATA_W  memory douta (1-cycle synchronous read)
mem_en  out  1  memory enable
mem_rw  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_din  out  DATA_W  memory write data

Behaviour:
- State: FSM {ARB, LOCK}, starve_cnt (clog2(STARVE_MAX+1) bits), l_rvalid register. Reset (reset=0, async) forces ARB, starve_cnt=0, l_rvalid=0.
- Combinational outputs are forced low while reset=0: l_gnt=0, p_stall=0, mem_en=0, mem_rw=0, mem_addr=0, mem_din=0.
- Grant decision is combinational, same cycle, no added latency on the pipeline path.
- ARB, l_req=0: pipe granted iff p_en. starve_cnt<=0.
- ARB, l_req=1, p_en=0: loader granted. starve_cnt<=0.
- ARB, l_req=1, p_en=1, starve_cnt<STARVE_MAX: pipe granted, l_gnt=0, starve_cnt<=starve_cnt+1.
- ARB, l_req=1, p_en=1, starve_cnt==STARVE_MAX: loader granted, p_stall=1, starve_cnt<=0.
- Entering LOCK: loader granted in ARB with l_lock=1 -> next state LOCK.
- LOCK: the loader is granted every cycle l_req=1. p_stall=p_en. starve_cnt held at 0.
- Leaving LOCK: stays while l_req&&l_lock. When l_req=0 -> ARB with no grant that cycle. When l_req=1, l_lock=0 -> this final access is granted, then ARB.
- Granted requester drives mem_en=1, mem_rw, mem_addr, mem_din from its inputs. With no grant, mem_en=0, mem_rw=0, addr/din=0.
- p_stall=1 only when p_en=1 and the pipeline was not granted. A stalled pipeline write must not reach memory.
- l_gnt=1 exactly on cycles the loader access drives memory.
- l_rvalid <= l_gnt & ~l_rw. l_rdata = l_rvalid ? mem_rdata : 0. Read latency is 1 cycle after the grant edge.
- Back-to-back loader reads give one l_rvalid per cycle, in order.
- Memory order is grant order: a write then a read to the same address in consecutive cycles returns the new data.
- Reset mid-LOCK: immediate return to ARB. A pending l_rvalid is cleared and is not delivered.
- STARVE_MAX=1: pipeline and loader alternate under continuous contention.

Test Plan:
- Reset, idle: reset=0 with random inputs -> mem_en=0, p_stall=0, l_gnt=0, l_rvalid=0. Release, p_en=1 p_rw=1 addr 0x10 data 0xA5 -> mem_en=1, mem_rw=1, mem_addr=0x10, mem_din=0xA5, p_stall=0.
- Loader alone: l_req=1 l_rw=1 write 0x3C to 0x20, then read 0x20 -> l_gnt=1 both cycles; l_rvalid=1 with l_rdata=0x3C on the cycle after the read grant.
- Starvation: p_en=1 and l_req=1 continuous, STARVE_MAX=4 -> pipe granted 4 cycles, loader 1 cycle (p_stall=1), repeating 5-cycle pattern; pipeline write during stall cycle absent from memory.
- Lock burst: l_lock=1, l_req=1 for 6 reads of 0x00..0x05 while p_en=1 -> 6 consecutive l_gnt, p_stall=1 all 6 cycles, l_rvalid 6 consecutive cycles with correct data. Drop l_lock on 6th -> ARB, pipe granted next cycle.
- Reset mid-lock: assert reset=0 during cycle 3 of a lock burst -> FSM ARB, l_rvalid=0 immediately. After release with p_en=1, l_req=1 -> pipe granted (starve_cnt restarted at 0).
